// File: rtl/cdc_fifo_src_sched_pkg.sv
// Shared state encoding and sizing helpers for the clearable CDC FIFO source scheduler.
package cdc_fifo_src_sched_pkg;

    localparam int unsigned StatBeatsW  = 32;
    localparam int unsigned StatClearsW = 16;

    typedef enum logic [2:0] {
        RUN,
        CLEAR,
        WAIT_RISE,
        WAIT_FALL,
        REMOTE
    } sched_state_e;

    // Width of a counter that must be able to hold the value 'cycles'.
    function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/cdc_fifo_src_sched_rr_arb_tree.sv
// Combinational round-robin arbiter with grant lock-in while the sink stalls,
// and a flush that drops the lock and rewinds the pointer to input 0.
module cdc_fifo_src_sched_rr_arb_tree #(
    parameter int unsigned NumIn  = 4,
    parameter type         T      = logic [31:0],
    parameter bit          LockIn = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic [NumIn-1:0] req_i,
    input  T                 data_i [NumIn],
    input  logic             gnt_i,
    output logic             req_o,
    output logic [NumIn-1:0] gnt_o,
    output T                 data_o
);

    localparam int unsigned IdxW = (NumIn > 1) ? $clog2(NumIn) : 1;
    localparam int unsigned SumW = IdxW + 1;

    logic [IdxW-1:0] rr_q, rr_d;
    logic [IdxW-1:0] lock_idx_q, lock_idx_d;
    logic            lock_q, lock_d;
    logic [IdxW-1:0] sel_idx;
    logic            found;
    logic [SumW-1:0] cand;

    // Winner search: locked index if held, else first request at or after the pointer.
    always_comb begin
        found   = 1'b0;
        sel_idx = rr_q;
        cand    = '0;
        if (LockIn && lock_q) begin
            sel_idx = lock_idx_q;
            found   = req_i[lock_idx_q];
        end else begin
            for (int unsigned k = 0; k < NumIn; k++) begin
                cand = SumW'(rr_q) + SumW'(k);
                if (cand >= SumW'(NumIn)) begin
                    cand = cand - SumW'(NumIn);
                end
                if (!found && req_i[cand[IdxW-1:0]]) begin
                    found   = 1'b1;
                    sel_idx = cand[IdxW-1:0];
                end
            end
        end
    end

    assign req_o  = found;
    assign data_o = data_i[sel_idx];

    always_comb begin
        gnt_o          = '0;
        gnt_o[sel_idx] = found & gnt_i;
    end

    always_comb begin
        rr_d       = rr_q;
        lock_d     = 1'b0;
        lock_idx_d = lock_idx_q;
        if (found && gnt_i) begin
            rr_d = (sel_idx == IdxW'(NumIn - 1)) ? '0 : sel_idx + IdxW'(1);
        end
        if (LockIn && found && !gnt_i) begin
            lock_d     = 1'b1;
            lock_idx_d = sel_idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: rtl/cdc_fifo_src_sched.sv
// Arbitrates NumReq requesters onto one clearable CDC FIFO source port and sequences
// local/remote clears with a timeout. Statistics counters exist only with CDC_FIFO_SRC_SCHED_STATS_EN.
module cdc_fifo_src_sched
    import cdc_fifo_src_sched_pkg::*;
#(
    parameter int unsigned NumReq        = 4,
    parameter type         T             = logic [31:0],
    parameter int unsigned TimeoutCycles = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumReq-1:0]      req_valid_i,
    input  T                       req_data_i [NumReq],
    output logic [NumReq-1:0]      req_ready_o,
    input  logic                   clear_req_i,
    output logic                   clear_done_o,
    output logic                   timeout_o,
    output logic                   fifo_valid_o,
    output T                       fifo_data_o,
    input  logic                   fifo_ready_i,
    output logic                   fifo_clear_o,
    input  logic                   fifo_clear_pending_i,
    output logic [StatBeatsW-1:0]  stat_beats_o,
    output logic [StatClearsW-1:0] stat_clears_o
);

    localparam int unsigned TmoW = tmo_cnt_width(TimeoutCycles);

    sched_state_e    state_q, state_d;
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            timeout_q, timeout_d;
    logic            clear_done_q, clear_done_d;

    logic              run;
    logic [NumReq-1:0] arb_req;
    logic [NumReq-1:0] arb_gnt;
    logic              arb_valid;
    T                  arb_data;

    // Traffic flows only in RUN and never while reset is asserted.
    assign run     = (state_q == RUN) && !rst_i;
    assign arb_req = req_valid_i & {NumReq{run}};

    cdc_fifo_src_sched_rr_arb_tree #(
        .NumIn  (NumReq),
        .T      (T),
        .LockIn (1'b1)
    ) i_rr_arb_tree (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (!run),
        .req_i   (arb_req),
        .data_i  (req_data_i),
        .gnt_i   (fifo_ready_i),
        .req_o   (arb_valid),
        .gnt_o   (arb_gnt),
        .data_o  (arb_data)
    );

    always_comb begin
        fifo_valid_o = arb_valid;
        fifo_data_o  = '0;
        if (arb_valid) begin
            fifo_data_o = arb_data;
        end
    end

    assign req_ready_o  = arb_gnt;
    assign fifo_clear_o = (state_q == CLEAR) && !rst_i;
    assign clear_done_o = clear_done_q && !rst_i;
    assign timeout_o    = timeout_q && !rst_i;

    // Clear sequencing; completion and remote release take precedence over the timeout.
    always_comb begin
        state_d      = state_q;
        tmo_cnt_d    = '0;
        timeout_d    = timeout_q;
        clear_done_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (clear_req_i) begin
                    state_d = CLEAR;
                end else if (fifo_clear_pending_i) begin
                    state_d = REMOTE;
                end
            end
            CLEAR: begin
                state_d = WAIT_RISE;
            end
            WAIT_RISE, WAIT_FALL, REMOTE: begin
                tmo_cnt_d = tmo_cnt_q + TmoW'(1);
                if (state_q == WAIT_FALL && !fifo_clear_pending_i) begin
                    state_d      = RUN;
                    tmo_cnt_d    = '0;
                    clear_done_d = 1'b1;
                end else if (state_q == REMOTE && !fifo_clear_pending_i) begin
                    state_d   = RUN;
                    tmo_cnt_d = '0;
                end else if (tmo_cnt_q == TmoW'(TimeoutCycles - 1)) begin
                    state_d   = RUN;
                    tmo_cnt_d = '0;
                    timeout_d = 1'b1;
                end else if (state_q == WAIT_RISE && fifo_clear_pending_i) begin
                    state_d = WAIT_FALL;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= RUN;
            tmo_cnt_q    <= '0;
            timeout_q    <= 1'b0;
            clear_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_cnt_q    <= tmo_cnt_d;
            timeout_q    <= timeout_d;
            clear_done_q <= clear_done_d;
        end
    end

`ifdef CDC_FIFO_SRC_SCHED_STATS_EN
    logic [StatBeatsW-1:0]  beats_q, beats_d;
    logic [StatClearsW-1:0] clears_q, clears_d;

    // Beat counter wraps; clear counter saturates.
    always_comb begin
        beats_d  = beats_q;
        clears_d = clears_q;
        if (arb_valid && fifo_ready_i) begin
            beats_d = beats_q + StatBeatsW'(1);
        end
        if (clear_done_d && (clears_q != '1)) begin
            clears_d = clears_q + StatClearsW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beats_q  <= '0;
            clears_q <= '0;
        end else begin
            beats_q  <= beats_d;
            clears_q <= clears_d;
        end
    end

    assign stat_beats_o  = rst_i ? '0 : beats_q;
    assign stat_clears_o = rst_i ? '0 : clears_q;
`else
    assign stat_beats_o  = '0;
    assign stat_clears_o = '0;
`endif

endmodule

// File: tb/tb_cdc_fifo_src_sched.sv
// Testbench for cdc_fifo_src_sched: directed vector table, clear/remote/timeout/reset
// sequences, then random traffic against a behavioural model.
module tb_cdc_fifo_src_sched;

    localparam int NR  = 4;
    localparam int TMO = 8;
`ifdef CDC_FIFO_SRC_SCHED_STATS_EN
    localparam bit StatsEn = 1'b1;
`else
    localparam bit StatsEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [31:0]   req_data [NR];
    logic          clear_req;
    logic          clear_done;
    logic          timeout;
    logic          fifo_valid;
    logic [31:0]   fifo_data;
    logic          fifo_ready;
    logic          fifo_clear;
    logic          pend;
    logic [31:0]   stat_beats;
    logic [15:0]   stat_clears;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdc_fifo_src_sched #(
        .NumReq        (NR),
        .T             (logic [31:0]),
        .TimeoutCycles (TMO)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .req_valid_i          (req_valid),
        .req_data_i           (req_data),
        .req_ready_o          (req_ready),
        .clear_req_i          (clear_req),
        .clear_done_o         (clear_done),
        .timeout_o            (timeout),
        .fifo_valid_o         (fifo_valid),
        .fifo_data_o          (fifo_data),
        .fifo_ready_i         (fifo_ready),
        .fifo_clear_o         (fifo_clear),
        .fifo_clear_pending_i (pend),
        .stat_beats_o         (stat_beats),
        .stat_clears_o        (stat_clears)
    );

    typedef struct {
        logic [NR-1:0] valid;
        logic          ready;
        logic          exp_valid;
        int            exp_idx;
        logic [NR-1:0] exp_ready;
        int            exp_beats;
    } vec_t;

    typedef enum int {M_RUN, M_CLR, M_WRISE, M_WFALL, M_REMOTE} mmode_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] stat_exp(input int n);
        return StatsEn ? 32'(n) : 32'h0;
    endfunction

    function automatic int pick(input logic [NR-1:0] v, input int start);
        for (int k = 0; k < NR; k++) begin
            if (v[(start + k) % NR]) return (start + k) % NR;
        end
        return -1;
    endfunction

    task automatic cyc(input logic [NR-1:0] v, input logic rdy, input logic clr,
                       input logic pnd, input logic r);
        @(negedge clk);
        req_valid  = v;
        fifo_ready = rdy;
        clear_req  = clr;
        pend       = pnd;
        rst        = r;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   vecs [12];
        mmode_t m_mode;
        int     m_ptr, m_lock, m_cnt, m_beats, m_clears;
        bit     m_tmo, m_done, done_next;
        int     gen_delay, gen_len, acc_idx, exp_idx;
        logic   r, exp_valid, hs;
        logic [NR-1:0] exp_ready;
        logic [31:0]   exp_data;

        // Arbitration table: alternation, grant lock under stall, pointer advance.
        vecs[0]  = '{4'b0101, 1'b1, 1'b1,  0, 4'b0001, 0};
        vecs[1]  = '{4'b0101, 1'b1, 1'b1,  2, 4'b0100, 1};
        vecs[2]  = '{4'b0101, 1'b1, 1'b1,  0, 4'b0001, 2};
        vecs[3]  = '{4'b0101, 1'b1, 1'b1,  2, 4'b0100, 3};
        vecs[4]  = '{4'b0010, 1'b0, 1'b1,  1, 4'b0000, 4};
        vecs[5]  = '{4'b1010, 1'b0, 1'b1,  1, 4'b0000, 4};
        vecs[6]  = '{4'b1010, 1'b0, 1'b1,  1, 4'b0000, 4};
        vecs[7]  = '{4'b1010, 1'b0, 1'b1,  1, 4'b0000, 4};
        vecs[8]  = '{4'b1010, 1'b0, 1'b1,  1, 4'b0000, 4};
        vecs[9]  = '{4'b1010, 1'b1, 1'b1,  1, 4'b0010, 4};
        vecs[10] = '{4'b1000, 1'b1, 1'b1,  3, 4'b1000, 5};
        vecs[11] = '{4'b0000, 1'b1, 1'b0, -1, 4'b0000, 6};

        for (int i = 0; i < NR; i++) req_data[i] = 32'hC0DE_0000 + 32'(i);
        req_valid = '0; fifo_ready = 1'b0; clear_req = 1'b0; pend = 1'b0; rst = 1'b1;

        // Reset: outputs held low even with requests and ready present.
        for (int i = 0; i < 3; i++) begin
            cyc(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
            chk("rst_valid", 32'(fifo_valid), 32'h0);
            chk("rst_data", fifo_data, 32'h0);
            chk("rst_clear", 32'(fifo_clear), 32'h0);
            chk("rst_done", 32'(clear_done), 32'h0);
            chk("rst_timeout", 32'(timeout), 32'h0);
            chk("rst_beats", stat_beats, 32'h0);
            chk("rst_clears", 32'(stat_clears), 32'h0);
        end

        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].valid, vecs[i].ready, 1'b0, 1'b0, 1'b0);
            chk("tbl_valid", 32'(fifo_valid), 32'(vecs[i].exp_valid));
            chk("tbl_ready", 32'(req_ready), 32'(vecs[i].exp_ready));
            chk("tbl_beats", stat_beats, stat_exp(vecs[i].exp_beats));
            if (vecs[i].exp_valid) chk("tbl_data", fifo_data, req_data[vecs[i].exp_idx]);
        end

        // Local clear with pending pulse of 6 cycles.
        cyc(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("clr_req_cycle_clear", 32'(fifo_clear), 32'h0);
        cyc(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("clr_clear_pulse", 32'(fifo_clear), 32'h1);
        chk("clr_valid_blocked", 32'(fifo_valid), 32'h0);
        chk("clr_ready_blocked", 32'(req_ready), 32'h0);
        for (int i = 0; i < 7; i++) begin
            cyc(4'b1111, 1'b1, 1'b0, (i < 6), 1'b0);
            chk("clr_wait_clear", 32'(fifo_clear), 32'h0);
            chk("clr_wait_valid", 32'(fifo_valid), 32'h0);
            chk("clr_wait_ready", 32'(req_ready), 32'h0);
            chk("clr_wait_done", 32'(clear_done), 32'h0);
        end
        cyc(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("clr_done_pulse", 32'(clear_done), 32'h1);
        chk("clr_run_valid", 32'(fifo_valid), 32'h1);
        chk("clr_run_ptr0", fifo_data, req_data[0]);
        chk("clr_stat_clears", 32'(stat_clears), stat_exp(1));
        cyc(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("clr_done_one_cycle", 32'(clear_done), 32'h0);

        // Remote clear: pending for 4 cycles without a local request.
        cyc(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(4'b1111, 1'b1, 1'b0, (i < 3), 1'b0);
            chk("rem_valid_blocked", 32'(fifo_valid), 32'h0);
            chk("rem_ready_blocked", 32'(req_ready), 32'h0);
            chk("rem_no_clear", 32'(fifo_clear), 32'h0);
        end
        cyc(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rem_back_run", 32'(fifo_valid), 32'h1);
        chk("rem_no_done", 32'(clear_done), 32'h0);
        cyc(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rem_no_done_late", 32'(clear_done), 32'h0);

        // Clear whose pending never rises: times out after TMO wait cycles.
        cyc(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("tmo_clear_pulse", 32'(fifo_clear), 32'h1);
        for (int i = 0; i < TMO; i++) begin
            cyc(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
            chk("tmo_not_yet", 32'(timeout), 32'h0);
            chk("tmo_wait_valid", 32'(fifo_valid), 32'h0);
            chk("tmo_ignored_clr", 32'(fifo_clear), 32'h0);
        end
        cyc(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("tmo_flag", 32'(timeout), 32'h1);
        chk("tmo_run_valid", 32'(fifo_valid), 32'h1);
        chk("tmo_no_done", 32'(clear_done), 32'h0);
        chk("tmo_clears_same", 32'(stat_clears), stat_exp(1));
        cyc(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("tmo_sticky", 32'(timeout), 32'h1);

        // Reset during WAIT_FALL abandons the clear.
        cyc(4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(4'b0000, 1'b1, 1'b0, 1'b1, 1'b0);
        cyc(4'b1111, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("rstwf_valid", 32'(fifo_valid), 32'h0);
        chk("rstwf_done", 32'(clear_done), 32'h0);
        cyc(4'b1111, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rstwf_run_valid", 32'(fifo_valid), 32'h1);
        chk("rstwf_run_data", fifo_data, req_data[0]);
        chk("rstwf_done_after", 32'(clear_done), 32'h0);
        chk("rstwf_timeout_clr", 32'(timeout), 32'h0);
        chk("rstwf_beats", stat_beats, 32'h0);
        chk("rstwf_clears", 32'(stat_clears), 32'h0);
        cyc(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rstwf_done_late", 32'(clear_done), 32'h0);
        chk("rstwf_beats_one", stat_beats, stat_exp(1));

        // Random traffic against the behavioural model.
        cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
        m_mode = M_RUN; m_ptr = 0; m_lock = -1; m_cnt = 0; m_beats = 0; m_clears = 0;
        m_tmo = 1'b0; m_done = 1'b0;
        gen_delay = 0; gen_len = 0; acc_idx = -1;

        for (int n = 0; n < 700; n++) begin
            @(negedge clk);
            if (acc_idx >= 0) req_valid[acc_idx] = 1'b0;
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    req_valid[i] = 1'b1;
                    req_data[i]  = $urandom;
                end
            end
            r          = ($urandom_range(0, 199) == 0);
            rst        = r;
            fifo_ready = ($urandom_range(0, 3) != 0);
            clear_req  = ($urandom_range(0, 19) == 0);
            pend       = (gen_len > 0) && (gen_delay == 0);
            #1;

            exp_idx = -1;
            if (!r && m_mode == M_RUN) exp_idx = (m_lock >= 0) ? m_lock : pick(req_valid, m_ptr);
            exp_valid = (exp_idx >= 0);
            hs        = exp_valid && fifo_ready;
            exp_ready = '0;
            exp_data  = 32'h0;
            if (exp_valid) begin
                exp_data = req_data[exp_idx];
                if (fifo_ready) exp_ready[exp_idx] = 1'b1;
            end

            chk("rnd_valid", 32'(fifo_valid), 32'(exp_valid));
            chk("rnd_data", fifo_data, exp_data);
            if (!r) chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
            chk("rnd_clear", 32'(fifo_clear), 32'(!r && m_mode == M_CLR));
            chk("rnd_done", 32'(clear_done), 32'(!r && m_done));
            chk("rnd_timeout", 32'(timeout), 32'(!r && m_tmo));
            chk("rnd_beats", stat_beats, r ? 32'h0 : stat_exp(m_beats));
            chk("rnd_clears", 32'(stat_clears), r ? 32'h0 : stat_exp(m_clears));

            acc_idx = hs ? exp_idx : -1;
            if (pend) gen_len--;
            else if (gen_len > 0) gen_delay--;
            if (gen_len == 0) begin
                if (!r && m_mode == M_CLR) begin
                    gen_delay = $urandom_range(0, 2);
                    gen_len   = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
                end else if ($urandom_range(0, 39) == 0) begin
                    gen_delay = 0;
                    gen_len   = $urandom_range(1, 4);
                end
            end

            if (r) begin
                m_mode = M_RUN; m_ptr = 0; m_lock = -1; m_cnt = 0;
                m_beats = 0; m_clears = 0; m_tmo = 1'b0; m_done = 1'b0;
            end else begin
                if (m_mode != M_RUN) begin
                    m_ptr = 0; m_lock = -1;
                end else if (hs) begin
                    m_ptr = (exp_idx + 1) % NR; m_lock = -1; m_beats++;
                end else begin
                    m_lock = exp_idx;
                end
                done_next = 1'b0;
                case (m_mode)
                    M_RUN: begin
                        m_cnt = 0;
                        if (clear_req) m_mode = M_CLR;
                        else if (pend) m_mode = M_REMOTE;
                    end
                    M_CLR: m_mode = M_WRISE;
                    default: begin
                        m_cnt++;
                        if (m_mode == M_WFALL && !pend) begin
                            m_mode = M_RUN; done_next = 1'b1;
                        end else if (m_mode == M_REMOTE && !pend) begin
                            m_mode = M_RUN;
                        end else if (m_cnt == TMO) begin
                            m_mode = M_RUN; m_tmo = 1'b1;
                        end else if (m_mode == M_WRISE && pend) begin
                            m_mode = M_WFALL;
                        end
                    end
                endcase
                m_done = done_next;
                if (done_next && m_clears < 65535) m_clears++;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
